// File: rtl/de2_115_sopc_sw_debounce_pkg.sv
// Shared constants for the DE2-115 slide-switch conditioning path,
// plus a width helper used to size the prescaler and per-bit counters.
package de2_115_sopc_sw_debounce_pkg;

    localparam int unsigned SW_WIDTH          = 18;
    localparam int unsigned CLK_HZ            = 50_000_000;
    // One debounce tick per millisecond at the system clock rate
    localparam int unsigned DEBOUNCE_TICK_DIV = CLK_HZ / 1000;
    localparam int unsigned SW_STABLE_TICKS   = 20;
    localparam int unsigned SW_SYNC_STAGES    = 2;

    // Bits needed to hold the values 0..n-1, never less than one bit
    function automatic int unsigned width_for_count(input int unsigned n);
        int unsigned w;
        w = (n < 2) ? 1 : int'($clog2(n));
        return w;
    endfunction

endpackage

// File: rtl/de2_115_sopc_debounce_bit.sv
// One switch bit: synchroniser chain followed by a stability counter that
// accepts a new level only after it has been seen for STABLE_TICKS ticks.
module de2_115_sopc_debounce_bit
    import de2_115_sopc_sw_debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = SW_SYNC_STAGES,
    parameter int unsigned STABLE_TICKS  = SW_STABLE_TICKS,
    parameter logic        RESET_VAL_BIT = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic raw,
    output logic clean,
    output logic changed
);

    localparam int unsigned      CNT_W    = width_for_count(STABLE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   sync;
    logic [CNT_W-1:0]       cnt;

    assign sync = sync_chain[SYNC_STAGES-1];

    // Plain flop chain bringing the asynchronous pin into the clk domain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_chain <= {SYNC_STAGES{RESET_VAL_BIT}};
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw};
        end
    end

    // Count ticks of continuous disagreement; any agreement restarts the count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            clean   <= RESET_VAL_BIT;
            changed <= 1'b0;
        end else if (sync == clean) begin
            cnt     <= '0;
            changed <= 1'b0;
        end else if (tick) begin
            if (cnt == CNT_LAST) begin
                cnt     <= '0;
                clean   <= sync;
                changed <= 1'b1;
            end else begin
                cnt     <= cnt + CNT_W'(1);
                changed <= 1'b0;
            end
        end else begin
            changed <= 1'b0;
        end
    end

endmodule

// File: rtl/de2_115_sopc_sw_debounce.sv
// Slide-switch conditioner feeding the switch PIO in_port: a shared tick
// prescaler and one synchronise-and-debounce slice per switch bit.
module de2_115_sopc_sw_debounce
    import de2_115_sopc_sw_debounce_pkg::*;
#(
    parameter int unsigned      WIDTH        = SW_WIDTH,
    parameter int unsigned      SYNC_STAGES  = SW_SYNC_STAGES,
    parameter int unsigned      TICK_DIV     = DEBOUNCE_TICK_DIV,
    parameter int unsigned      STABLE_TICKS = SW_STABLE_TICKS,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_changed
);

    logic tick;

    generate
        if (TICK_DIV == 1) begin : g_tick_always
            assign tick = 1'b1;
        end else begin : g_prescaler
            localparam int unsigned      PRE_W    = width_for_count(TICK_DIV);
            localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

            logic [PRE_W-1:0] pre_cnt;

            // Free-running divider; tick marks its terminal count
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pre_cnt <= '0;
                end else if (pre_cnt == PRE_LAST) begin
                    pre_cnt <= '0;
                end else begin
                    pre_cnt <= pre_cnt + PRE_W'(1);
                end
            end

            assign tick = (pre_cnt == PRE_LAST);
        end
    endgenerate

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            de2_115_sopc_debounce_bit #(
                .SYNC_STAGES   (SYNC_STAGES),
                .STABLE_TICKS  (STABLE_TICKS),
                .RESET_VAL_BIT (RESET_VAL[i])
            ) u_bit (
                .clk     (clk),
                .reset_n (reset_n),
                .tick    (tick),
                .raw     (sw_raw[i]),
                .clean   (sw_clean[i]),
                .changed (sw_changed[i])
            );
        end
    endgenerate

endmodule
